// File: rtl/ila_stream_packer.sv
// ----------------------------------------------------------------------------
// ila_stream_packer
//
// Packs a fixed-length capture of narrow ILA samples into wide AXI-Stream
// words. A start pulse latches the number of samples to collect; samples are
// then pulled from the ILA one per clock (when offered). PACK samples are
// concatenated LSB-first into one output word. The final word of the capture
// may be partially filled; its unused upper lanes are zero and it carries
// tlast. A done pulse follows acceptance of the tlast word.
//
// Ports
//   clk               rising-edge clock
//   rst               synchronous active-high reset
//   start             one-cycle pulse, arms a capture (ignored unless idle)
//   total_samples_in  samples to pack in this capture (0 = ignored)
//   sample_in         ILA sample data
//   sample_valid_in   ILA sample available
//   sample_pulled     combinational, sample consumed on this rising edge
//   m_axis_tdata      packed output word
//   m_axis_tvalid     output word valid
//   m_axis_tready     downstream ready
//   m_axis_tlast      last word of the capture
//   busy              capture in progress (state != IDLE)
//   done              one-cycle pulse after the tlast word is accepted
//
// WORD_WIDTH must be an integer multiple of SAMPLE_WIDTH, with at least two
// samples per word.
// ----------------------------------------------------------------------------
module ila_stream_packer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int WORD_WIDTH   = 32,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [COUNT_WIDTH-1:0]  total_samples_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid_in,
  output logic                    sample_pulled,
  output logic [WORD_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    busy,
  output logic                    done
);

  localparam int                PACK      = WORD_WIDTH / SAMPLE_WIDTH;
  localparam int                LANE_W    = $clog2(PACK);
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PACK - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PACK,
    ST_DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [COUNT_WIDTH-1:0]  total_q, total_d;
  logic [COUNT_WIDTH-1:0]  count_q, count_d;
  logic [LANE_W-1:0]       lane_q,  lane_d;
  logic [WORD_WIDTH-1:0]   acc_q,   acc_d;
  logic [WORD_WIDTH-1:0]   tdata_q, tdata_d;
  logic                    tvalid_q, tvalid_d;
  logic                    tlast_q,  tlast_d;
  logic                    done_q,   done_d;

  logic                    xfer;
  logic                    last_sample;
  logic                    word_end;
  logic                    stall;
  logic                    pull;
  logic [WORD_WIDTH-1:0]   word_next;

  // NOTE: every variable gets a default at the top of the block, so no path
  // leaves one unassigned and no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    count_d  = count_q;
    lane_d   = lane_q;
    acc_d    = acc_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    done_d   = 1'b0;

    xfer        = tvalid_q && m_axis_tready;
    last_sample = (count_q == total_q - COUNT_WIDTH'(1));
    word_end    = (lane_q == LANE_LAST) || last_sample;
    // A word-completing sample needs the output register; hold it off only
    // while an unaccepted word still occupies that register.
    stall       = word_end && tvalid_q && !m_axis_tready;
    pull        = (state_q == ST_PACK) && sample_valid_in && !stall;

    // Accumulator with the current sample dropped into its lane.
    word_next = acc_q;
    for (int k = 0; k < PACK; k++) begin
      if (lane_q == LANE_W'(k)) begin
        word_next[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_in;
      end
    end

    // Retire the held word; a load below may refill it on the same edge.
    if (xfer) begin
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && (total_samples_in != '0)) begin
          state_d = ST_PACK;
          total_d = total_samples_in;
          count_d = '0;
          lane_d  = '0;
          acc_d   = '0;
        end
      end

      ST_PACK: begin
        if (pull) begin
          count_d = count_q + COUNT_WIDTH'(1);
          if (word_end) begin
            tdata_d  = word_next;
            tvalid_d = 1'b1;
            tlast_d  = last_sample;
            acc_d    = '0;
            lane_d   = '0;
            if (last_sample) begin
              state_d = ST_DRAIN;
            end
          end else begin
            acc_d  = word_next;
            lane_d = lane_q + LANE_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (xfer && tlast_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      total_q  <= '0;
      count_q  <= '0;
      lane_q   <= '0;
      acc_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      count_q  <= count_d;
      lane_q   <= lane_d;
      acc_q    <= acc_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      done_q   <= done_d;
    end
  end

  // Gated by rst so no sample is reported consumed during a reset cycle.
  assign sample_pulled = pull && !rst;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;

endmodule

// File: tb/tb_ila_stream_packer.sv
// ----------------------------------------------------------------------------
// tb_ila_stream_packer
//
// Directed bench for ila_stream_packer at default parameters (16-bit samples,
// 32-bit words). Inputs change on the falling edge; outputs are observed 1 ns
// later, i.e. in the same cycle they describe and well away from the rising
// edge. run_capture drives one capture and records what the DUT did; each
// test task compares those records to hand-computed values.
// ----------------------------------------------------------------------------
module tb_ila_stream_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] total_samples_in;
  logic [15:0] sample_in;
  logic        sample_valid_in;
  logic        sample_pulled;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        busy;
  logic        done;

  ila_stream_packer dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .total_samples_in (total_samples_in),
    .sample_in        (sample_in),
    .sample_valid_in  (sample_valid_in),
    .sample_pulled    (sample_pulled),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Sample source and per-capture observations.
  logic [15:0] src[$];
  logic [31:0] got_data[$];
  logic        got_last[$];
  int          pulls, first_pull, last_pull, bad_pulls, stall_drops;
  int          stable_err, done_cnt, done_cyc, xfer_last_cyc;
  logic        done_busy;
  bit          timed_out;

  // Runs one capture from IDLE. valid_mode 0: valid whenever samples remain,
  // 1: valid only on odd cycles. stall_cycles: tready low for that many cycles
  // right after the first word transfers. restart_cyc: cycle on which a
  // second start (total 2) is pulsed, 0 = never.
  task automatic run_capture(input int total, input int valid_mode,
                             input int stall_cycles, input int restart_cyc);
    int          idx = 0;
    int          stall_left = 0;
    logic        hold = 1'b0;
    logic [31:0] hold_data = '0;
    logic        hold_last = 1'b0;
    got_data.delete();
    got_last.delete();
    pulls = 0; first_pull = -1; last_pull = -1; bad_pulls = 0;
    stall_drops = 0; stable_err = 0; done_cnt = 0; done_cyc = -1;
    xfer_last_cyc = -1; done_busy = 1'b1; timed_out = 1'b0;

    start = 1'b1; total_samples_in = 16'(total);
    sample_valid_in = 1'b0; m_axis_tready = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      start            = (cyc == restart_cyc);
      total_samples_in = (cyc == restart_cyc) ? 16'd2 : 16'(total);
      sample_valid_in  = (idx < src.size()) && (valid_mode == 0 || cyc % 2 == 1);
      sample_in        = (idx < src.size()) ? src[idx] : 16'h0;
      m_axis_tready    = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      if (sample_pulled) begin
        if (!sample_valid_in) bad_pulls++;
        if (first_pull < 0) first_pull = cyc;
        last_pull = cyc;
        pulls++;
        idx++;
      end
      if (sample_valid_in && !sample_pulled && m_axis_tvalid && !m_axis_tready)
        stall_drops++;
      if (hold && (m_axis_tdata !== hold_data || m_axis_tlast !== hold_last))
        stable_err++;
      hold      = m_axis_tvalid && !m_axis_tready;
      hold_data = m_axis_tdata;
      hold_last = m_axis_tlast;
      if (m_axis_tvalid && m_axis_tready) begin
        got_data.push_back(m_axis_tdata);
        got_last.push_back(m_axis_tlast);
        if (m_axis_tlast) xfer_last_cyc = cyc;
        if (got_data.size() == 1 && stall_cycles > 0) stall_left = stall_cycles;
      end
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy;
      end
      @(negedge clk);
      if (done_cyc > 0 && cyc == done_cyc + 1) break;
    end
    start = 1'b0;
    sample_valid_in = 1'b0;
    if (done_cyc < 0) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0; total_samples_in = '0; sample_in = '0;
    sample_valid_in = 1'b1; m_axis_tready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({m_axis_tvalid, m_axis_tlast, done, busy, sample_pulled} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got tvalid=%b tlast=%b done=%b busy=%b pulled=%b exp all 0",
               m_axis_tvalid, m_axis_tlast, done, busy, sample_pulled);
    end
    checks++;
    if (m_axis_tdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_tdata got %h exp 00000000", m_axis_tdata);
    end
    rst = 1'b0;
    sample_valid_in = 1'b0; m_axis_tready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_pack4();
    logic [31:0] exp_w[2] = '{32'h22221111, 32'h44443333};
    src = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_capture(4, 0, 0, 0);
    checks++;
    if (timed_out || got_data.size() != 2) begin
      errors++;
      $display("FAIL pack4_words got %0d words (timeout=%0b) exp 2", got_data.size(), timed_out);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== exp_w[i] || got_last[i] !== (i == 1)) begin
        errors++;
        $display("FAIL pack4_word%0d got %h/last=%b exp %h/last=%b",
                 i, got_data[i], got_last[i], exp_w[i], (i == 1));
      end
    end
    checks++;
    if (pulls != 4 || first_pull != 1 || last_pull != 4 || bad_pulls != 0) begin
      errors++;
      $display("FAIL pack4_back_to_back got pulls=%0d cycles %0d..%0d bad=%0d exp 4 in 1..4",
               pulls, first_pull, last_pull, bad_pulls);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 6 || done_cyc != xfer_last_cyc + 1 || done_busy !== 1'b0) begin
      errors++;
      $display("FAIL pack4_done got cnt=%0d cyc=%0d last_xfer=%0d busy=%b exp 1/6/5/0",
               done_cnt, done_cyc, xfer_last_cyc, done_busy);
    end
  endtask

  task automatic test_partial_word();
    logic [31:0] exp_w[2] = '{32'h000B000A, 32'h0000000C};
    // A fourth sample stays on offer: the capture must stop after exactly 3.
    src = {16'h000A, 16'h000B, 16'h000C, 16'h000D};
    run_capture(3, 0, 0, 0);
    checks++;
    if (timed_out || got_data.size() != 2) begin
      errors++;
      $display("FAIL partial_words got %0d words (timeout=%0b) exp 2", got_data.size(), timed_out);
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== exp_w[i] || got_last[i] !== (i == 1)) begin
        errors++;
        $display("FAIL partial_word%0d got %h/last=%b exp %h/last=%b",
                 i, got_data[i], got_last[i], exp_w[i], (i == 1));
      end
    end
    checks++;
    if (pulls != 3 || bad_pulls != 0) begin
      errors++;
      $display("FAIL partial_pulls got %0d (bad=%0d) exp 3", pulls, bad_pulls);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != xfer_last_cyc + 1 || done_busy !== 1'b0) begin
      errors++;
      $display("FAIL partial_done got cnt=%0d cyc=%0d last_xfer=%0d busy=%b exp 1/last_xfer+1/0",
               done_cnt, done_cyc, xfer_last_cyc, done_busy);
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_w[4] = '{32'h10021001, 32'h10041003, 32'h10061005, 32'h10081007};
    src = {16'h1001, 16'h1002, 16'h1003, 16'h1004,
           16'h1005, 16'h1006, 16'h1007, 16'h1008};
    run_capture(8, 0, 5, 0);
    checks++;
    if (timed_out || got_data.size() != 4) begin
      errors++;
      $display("FAIL stall_words got %0d words (timeout=%0b) exp 4", got_data.size(), timed_out);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== exp_w[i] || got_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL stall_word%0d got %h/last=%b exp %h/last=%b",
                 i, got_data[i], got_last[i], exp_w[i], (i == 3));
      end
    end
    // Stalled from cycle 4: lane-0 sample in cycle 5 may go, the completing
    // one waits through cycles 6..8.
    checks++;
    if (stall_drops != 3 || pulls != 8 || stable_err != 0) begin
      errors++;
      $display("FAIL stall_flow got drops=%0d pulls=%0d unstable=%0d exp 3/8/0",
               stall_drops, pulls, stable_err);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 13 || done_busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_done got cnt=%0d cyc=%0d busy=%b exp 1/13/0", done_cnt, done_cyc, done_busy);
    end
  endtask

  task automatic test_valid_toggle();
    logic [31:0] exp_w[2] = '{32'h22221111, 32'h44443333};
    src = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_capture(4, 1, 0, 0);
    checks++;
    if (timed_out || got_data.size() != 2 || got_data[0] !== exp_w[0] || got_data[1] !== exp_w[1]
        || got_last[1] !== 1'b1) begin
      errors++;
      $display("FAIL toggle_words got n=%0d %h %h exp 2 %h %h(last)",
               got_data.size(), got_data[0], got_data[1], exp_w[0], exp_w[1]);
    end
    checks++;
    if (pulls != 4 || bad_pulls != 0 || first_pull != 1 || last_pull != 7) begin
      errors++;
      $display("FAIL toggle_pulls got %0d bad=%0d cycles %0d..%0d exp 4/0/1..7",
               pulls, bad_pulls, first_pull, last_pull);
    end
  endtask

  task automatic test_start_ignored();
    logic [31:0] exp_w[2] = '{32'h22221111, 32'h44443333};
    int bad = 0;
    start = 1'b1; total_samples_in = 16'd0; sample_valid_in = 1'b1; sample_in = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (busy !== 1'b0 || sample_pulled !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL zero_start got %0d cycles busy/pulled exp 0", bad);
    end
    // A second start (total 2) mid-capture must leave the capture untouched.
    src = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_capture(4, 0, 0, 2);
    checks++;
    if (timed_out || got_data.size() != 2 || got_data[0] !== exp_w[0] || got_data[1] !== exp_w[1]
        || got_last[1] !== 1'b1 || pulls != 4) begin
      errors++;
      $display("FAIL busy_start got n=%0d %h %h pulls=%0d exp 2 %h %h pulls=4",
               got_data.size(), got_data[0], got_data[1], pulls, exp_w[0], exp_w[1]);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] exp_w[2] = '{32'h22221111, 32'h44443333};
    int dones = 0;
    start = 1'b1; total_samples_in = 16'd4; sample_valid_in = 1'b1;
    sample_in = 16'h00A1; m_axis_tready = 1'b0;
    @(negedge clk);
    start = 1'b0;                       // cycle 1: lane 0
    @(negedge clk);
    sample_in = 16'h00A2;               // cycle 2: completes word 0
    @(negedge clk);
    sample_in = 16'h00A3;               // cycle 3: word 0 held by tready=0
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h00A200A1) begin
      errors++;
      $display("FAIL abort_held got tvalid=%b tdata=%h exp 1 00A200A1", m_axis_tvalid, m_axis_tdata);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (sample_pulled !== 1'b0) begin
      errors++;
      $display("FAIL abort_pull_in_rst got %b exp 0", sample_pulled);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || sample_pulled !== 1'b0) begin
      errors++;
      $display("FAIL abort_after got tvalid=%b busy=%b pulled=%b exp 0 0 0",
               m_axis_tvalid, busy, sample_pulled);
    end
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL abort_done got %0d pulses exp 0", dones);
    end
    // rst and start together: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; total_samples_in = 16'd4;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_over_start got busy=%b exp 0", busy);
    end
    @(negedge clk);
    m_axis_tready = 1'b1;
    src = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_capture(4, 0, 0, 0);
    checks++;
    if (timed_out || got_data.size() != 2 || got_data[0] !== exp_w[0] || got_data[1] !== exp_w[1]
        || got_last[1] !== 1'b1 || done_cnt != 1 || done_cyc != 6) begin
      errors++;
      $display("FAIL fresh_capture got n=%0d %h %h done_cnt=%0d done_cyc=%0d exp 2 %h %h 1 6",
               got_data.size(), got_data[0], got_data[1], done_cnt, done_cyc, exp_w[0], exp_w[1]);
    end
  endtask

  initial begin
    test_reset();
    test_pack4();
    test_partial_word();
    test_stall();
    test_valid_toggle();
    test_start_ignored();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
